// File: rtl/pt2272_decoder_param.sv
// pt2272_decoder_param
// Receiver for the pulse-width-coded stream of a PT2262-class encoder.
// It measures high/low run lengths in ticks of a CLK_DIV-clk divider and
// classifies each high/low pair as 0, 1 or F. The frame is A0..A(N_ADDR-1),
// then D0..D(N_DATA-1), terminated by a sync. The address is compared against
// the trinary setting A. D is loaded only after CONFIRM consecutive
// identical matching frames.
// Ports:
//   clk       system clock
//   reset     synchronous reset, active high
//   A         address setting, 2 bits per symbol: 00=0, 11=1, 10=F, 01=never matches
//   cod_i     coded serial input (asynchronous)
//   D         received data, registered
//   dv        a confirmed transmission is present (drops after HOLD_TICKS idle ticks)
//   new_frame one-clk pulse when D is loaded with a newly confirmed value
//   frame_err one-clk pulse on a symbol or framing error
module pt2272_decoder_param #(
    parameter int N_ADDR     = 8,
    parameter int N_DATA     = 4,
    parameter int CLK_DIV    = 250,
    parameter int TOL        = 2,
    parameter int CONFIRM    = 2,
    parameter int HOLD_TICKS = 1024,
    parameter int MOMENTARY  = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2*N_ADDR-1:0] A,
    input  logic                cod_i,
    output logic [N_DATA-1:0]   D,
    output logic                dv,
    output logic                new_frame,
    output logic                frame_err
);
    localparam int N_SYM    = N_ADDR + N_DATA;
    localparam int RUN_MAX  = 124 + TOL;
    localparam int SYNC_LOW = 124 - TOL;
    localparam int RUN_W    = $clog2(RUN_MAX + 1);
    localparam int DIV_W    = $clog2(CLK_DIV + 1);
    localparam int CNT_W    = $clog2(N_SYM + 2);
    localparam int HOLD_W   = $clog2(HOLD_TICKS + 1);

    localparam logic [1:0] SYM_0 = 2'b00;
    localparam logic [1:0] SYM_1 = 2'b11;
    localparam logic [1:0] SYM_F = 2'b10;

    typedef enum logic [1:0] {HUNT, RX, CHECK} state_t;

    // ---------------- tick divider and input synchroniser ----------------
    logic [DIV_W-1:0] div_reg;
    logic             tick;
    logic [1:0]       sync_reg;
    logic             lvl;

    assign tick = (div_reg == DIV_W'(CLK_DIV - 1));
    assign lvl  = sync_reg[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg  <= '0;
            sync_reg <= '0;
        end else begin
            div_reg  <= tick ? '0 : div_reg + 1'b1;
            sync_reg <= {sync_reg[0], cod_i};
        end
    end

    // ---------------- run-length counters ----------------
    // high_reg restarts at a rising edge and low_reg at a falling edge, so at
    // the rising edge closing a symbol both still hold the complete runs.
    logic             prev_reg;
    logic [RUN_W-1:0] high_reg;
    logic [RUN_W-1:0] low_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_reg <= 1'b0;
            high_reg <= '0;
            low_reg  <= '0;
        end else if (tick) begin
            prev_reg <= lvl;
            if (lvl) begin
                if (!prev_reg)
                    high_reg <= RUN_W'(1);
                else if (high_reg != RUN_W'(RUN_MAX))
                    high_reg <= high_reg + 1'b1;
            end else begin
                if (prev_reg)
                    low_reg <= RUN_W'(1);
                else if (low_reg != RUN_W'(RUN_MAX))
                    low_reg <= low_reg + 1'b1;
            end
        end
    end

    function automatic logic in_win(input logic [RUN_W-1:0] x, input int nom);
        return (int'(x) >= nom - TOL) && (int'(x) <= nom + TOL);
    endfunction

    // ---------------- symbol / sync classification ----------------
    logic       rise, long_high, sync_tick, sync_ev, sym_ev, sym_ok, run_bad;
    logic [1:0] sym_code;

    always_comb begin
        rise      = tick && lvl && !prev_reg;
        // fires on the tick where the high run would become 24+TOL+1
        long_high = tick && lvl && prev_reg && (high_reg == RUN_W'(24 + TOL));
        // the tick on which the low run reaches SYNC_LOW; no need to wait for an edge
        sync_tick = tick && !lvl && !prev_reg && (low_reg == RUN_W'(SYNC_LOW - 1));
        sync_ev   = sync_tick && in_win(high_reg, 4);
        // a rising edge after a sync-length low only closes the sync itself
        sym_ev    = rise && (low_reg < RUN_W'(SYNC_LOW));
        sym_code  = SYM_F;
        sym_ok    = 1'b1;
        if (in_win(high_reg, 24) && in_win(low_reg, 8))
            sym_code = SYM_1;
        else if (in_win(high_reg, 8) && in_win(low_reg, 24))
            sym_code = SYM_0;
        else if (in_win(high_reg, 16) && in_win(low_reg, 16))
            sym_code = SYM_F;
        else
            sym_ok = 1'b0;
        run_bad = long_high || (sync_tick && !in_win(high_reg, 4)) || (sym_ev && !sym_ok);
    end

    // ---------------- frame registers and address match ----------------
    state_t              state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                bad_reg;
    logic [2*N_ADDR-1:0] addr_reg;
    logic [N_DATA-1:0]   data_reg;
    logic [N_DATA-1:0]   last_reg;
    logic [2:0]          mcnt_reg;
    logic [HOLD_W-1:0]   hold_reg;
    logic [N_ADDR-1:0]   match_bits;
    logic                addr_match;
    logic [2:0]          mc_next;
    logic                confirm;

    // received symbols are never 01, so a reserved code in A can never match
    generate
        for (genvar gi = 0; gi < N_ADDR; gi++) begin : g_match
            assign match_bits[gi] = (addr_reg[2*gi +: 2] == A[2*gi +: 2]);
        end
    endgenerate

    assign addr_match = &match_bits;

    always_comb begin
        mc_next = 3'd1;
        if (mcnt_reg != 3'd0 && data_reg == last_reg)
            mc_next = (mcnt_reg >= 3'(CONFIRM)) ? 3'(CONFIRM) : mcnt_reg + 3'd1;
        confirm = (state_reg == CHECK) && !bad_reg && addr_match && (mc_next == 3'(CONFIRM));
    end

    // ---------------- frame FSM, confirmation and hold timer ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= HUNT;
            cnt_reg   <= '0;
            bad_reg   <= 1'b0;
            addr_reg  <= '0;
            data_reg  <= '0;
            last_reg  <= '0;
            mcnt_reg  <= '0;
            hold_reg  <= '0;
            D         <= '0;
            dv        <= 1'b0;
            new_frame <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            new_frame <= 1'b0;
            frame_err <= 1'b0;

            // expiry first; a confirmation later in this block overrides it
            if (tick && dv) begin
                if (hold_reg <= HOLD_W'(1)) begin
                    hold_reg <= '0;
                    dv       <= 1'b0;
                    if (MOMENTARY != 0)
                        D <= '0;
                end else begin
                    hold_reg <= hold_reg - 1'b1;
                end
            end

            case (state_reg)
                HUNT: begin
                    if (sync_ev) begin
                        state_reg <= RX;
                        cnt_reg   <= '0;
                        bad_reg   <= 1'b0;
                    end
                end
                RX: begin
                    if (run_bad) begin
                        frame_err <= 1'b1;
                        mcnt_reg  <= '0;
                        state_reg <= HUNT;
                    end else if (sym_ev) begin
                        for (int i = 0; i < N_ADDR; i++)
                            if (cnt_reg == CNT_W'(i))
                                addr_reg[2*i +: 2] <= sym_code;
                        for (int i = 0; i < N_DATA; i++)
                            if (cnt_reg == CNT_W'(N_ADDR + i))
                                data_reg[i] <= sym_code[0];
                        if (cnt_reg != CNT_W'(N_SYM + 1))
                            cnt_reg <= cnt_reg + 1'b1;
                        if ((cnt_reg >= CNT_W'(N_ADDR) && cnt_reg < CNT_W'(N_SYM) && sym_code == SYM_F)
                            || cnt_reg >= CNT_W'(N_SYM)) begin
                            frame_err <= 1'b1;
                            bad_reg   <= 1'b1;
                            mcnt_reg  <= '0;
                        end
                    end else if (sync_ev) begin
                        cnt_reg <= '0;
                        if (cnt_reg == CNT_W'(N_SYM)) begin
                            state_reg <= CHECK;
                        end else begin
                            // wrong length: the sync still realigns the next frame
                            frame_err <= 1'b1;
                            bad_reg   <= 1'b0;
                            mcnt_reg  <= '0;
                        end
                    end
                end
                CHECK: begin
                    state_reg <= RX;
                    bad_reg   <= 1'b0;
                    if (bad_reg || !addr_match) begin
                        mcnt_reg <= '0;
                    end else begin
                        mcnt_reg <= mc_next;
                        last_reg <= data_reg;
                    end
                    if (confirm) begin
                        new_frame <= !dv || (D != data_reg);
                        D         <= data_reg;
                        dv        <= 1'b1;
                        hold_reg  <= HOLD_W'(HOLD_TICKS);
                    end
                end
                default: state_reg <= HUNT;
            endcase
        end
    end
endmodule

// File: tb/tb_pt2272_decoder_param.sv
// tb_pt2272_decoder_param
// Scoreboard bench for pt2272_decoder_param. Two instances share one input
// stream: u_dut_l (latched D) and u_dut_m (momentary D). Every frame sent
// pushes its expected outcome (new_frame and frame_err pulse counts, D and
// dv) onto a queue. That entry is popped and compared once the frame's
// trailing sync has been fully driven.
module tb_pt2272_decoder_param;
    localparam int NA   = 8;
    localparam int ND   = 4;
    localparam int DIV  = 3;
    localparam int TOL  = 2;
    localparam int CONF = 2;
    localparam int HOLD = 2500;

    logic          clk = 1'b0;
    logic          reset;
    logic [2*NA-1:0] A;
    logic          cod_i;
    logic [ND-1:0] D_l, D_m;
    logic          dv_l, dv_m, nf_l, nf_m, fe_l, fe_m;

    always #5 clk = ~clk;

    pt2272_decoder_param #(.N_ADDR(NA), .N_DATA(ND), .CLK_DIV(DIV), .TOL(TOL),
        .CONFIRM(CONF), .HOLD_TICKS(HOLD), .MOMENTARY(0)) u_dut_l (
        .clk(clk), .reset(reset), .A(A), .cod_i(cod_i),
        .D(D_l), .dv(dv_l), .new_frame(nf_l), .frame_err(fe_l));

    pt2272_decoder_param #(.N_ADDR(NA), .N_DATA(ND), .CLK_DIV(DIV), .TOL(TOL),
        .CONFIRM(CONF), .HOLD_TICKS(HOLD), .MOMENTARY(1)) u_dut_m (
        .clk(clk), .reset(reset), .A(A), .cod_i(cod_i),
        .D(D_m), .dv(dv_m), .new_frame(nf_m), .frame_err(fe_m));

    typedef struct {
        int            nf;
        int            er;
        logic [ND-1:0] d;
        logic          dv;
    } exp_t;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   frame_no = 0;

    // pulse / event monitor, sampled on the falling edge
    int   cyc = 0, nf_total = 0, err_total = 0, nf_cyc = 0, fall_cyc = 0;
    logic dv_prev = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (nf_l) begin
            nf_total <= nf_total + 1;
            nf_cyc   <= cyc;
        end
        if (fe_l)
            err_total <= err_total + 1;
        dv_prev <= dv_l;
        if (dv_prev && !dv_l)
            fall_cyc <= cyc;
    end

    // frame-level reference state
    int            m_cnt;
    logic [ND-1:0] m_last, m_d;
    logic          m_dv;
    int            fr[16];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_last = '0;
        m_d    = '0;
        m_dv   = 1'b0;
    endtask

    task automatic run(input logic v, input int ticks);
        cod_i = v;
        repeat (ticks * DIV) @(negedge clk);
    endtask

    task automatic send_sym(input int s, input int hi);
        int h, l;
        case (s)
            1:       begin h = 24; l = 8;  end
            0:       begin h = 8;  l = 24; end
            default: begin h = 16; l = 16; end
        endcase
        if (hi > 0)
            h = hi;
        run(1'b1, h);
        run(1'b0, l);
    endtask

    task automatic send_sync();
        run(1'b1, 4);
        run(1'b0, 128);
    endtask

    // address symbols all 0 except symbol 3, then the data bits
    task automatic load_frame(input int s3, input logic [ND-1:0] d);
        for (int i = 0; i < NA; i++)
            fr[i] = (i == 3) ? s3 : 0;
        for (int i = 0; i < ND; i++)
            fr[NA + i] = d[i] ? 1 : 0;
    endtask

    function automatic int a_code(input int i);
        logic [1:0] c;
        c = A[2*i +: 2];
        case (c)
            2'b00:   return 0;
            2'b11:   return 1;
            2'b10:   return 2;
            default: return -1;
        endcase
    endfunction

    task automatic sb_check(input int nf0, input int er0);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        frame_no++;
        $display("frame %0d: new_frame=%0d frame_err=%0d D=%b dv=%0d (expect %0d %0d %b %0d)",
                 frame_no, nf_total - nf0, err_total - er0, D_l, dv_l, e.nf, e.er, e.d, e.dv);
        chk("new_frame", nf_total - nf0, e.nf);
        chk("frame_err", err_total - er0, e.er);
        chk("D", D_l, e.d);
        chk("dv", dv_l, e.dv);
    endtask

    // send fr[0..n-1] plus a trailing sync; hi_idx/hi_ticks stretch one high run
    task automatic send_frame(input int n, input int hi_idx, input int hi_ticks);
        exp_t          e;
        logic          err, match;
        logic [ND-1:0] data;
        int            nf0, er0;
        err = (n != NA + ND) || (hi_idx >= 0 && hi_ticks > 24 + TOL);
        for (int i = NA; i < n; i++)
            if (fr[i] == 2)
                err = 1'b1;
        match = 1'b1;
        for (int i = 0; i < NA; i++)
            if (a_code(i) != fr[i])
                match = 1'b0;
        for (int i = 0; i < ND; i++)
            data[i] = (fr[NA + i] == 1);
        e.nf = 0;
        e.er = err ? 1 : 0;
        if (err || !match) begin
            m_cnt = 0;
        end else begin
            if (m_cnt > 0 && data == m_last)
                m_cnt = (m_cnt + 1 > CONF) ? CONF : m_cnt + 1;
            else
                m_cnt = 1;
            m_last = data;
            if (m_cnt == CONF) begin
                e.nf = (!m_dv || m_d != data) ? 1 : 0;
                m_d  = data;
                m_dv = 1'b1;
            end
        end
        e.d  = m_d;
        e.dv = m_dv;
        sb_q.push_back(e);
        nf0 = nf_total;
        er0 = err_total;
        for (int i = 0; i < n; i++)
            send_sym(fr[i], (i == hi_idx) ? hi_ticks : -1);
        send_sync();
        sb_check(nf0, er0);
    endtask

    task automatic pulse_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int nf0, er0, delta;
        reset = 1'b1;
        cod_i = 1'b0;
        A     = 16'h0000;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_D", D_l, 0);
        chk("rst_dv", dv_l, 0);
        chk("rst_new_frame", nf_l, 0);
        chk("rst_frame_err", fe_l, 0);
        chk("rst_D_m", D_m, 0);
        reset = 1'b0;

        // all-zero address, data 0,1,0,1 -> D = 4'b1010 after two frames
        run(1'b0, 10);
        send_sync();
        load_frame(0, 4'b1010);
        send_frame(12, -1, 0);
        send_frame(12, -1, 0);
        send_frame(12, -1, 0);

        // reset in the middle of a frame, then the trailing sync only aligns
        for (int i = 0; i < 5; i++)
            send_sym(fr[i], -1);
        run(1'b1, 5);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        chk("midrst_D", D_l, 0);
        chk("midrst_dv", dv_l, 0);
        chk("midrst_new_frame", nf_l, 0);
        chk("midrst_frame_err", fe_l, 0);
        reset = 1'b0;
        model_reset();
        nf0 = nf_total;
        er0 = err_total;
        run(1'b1, 3);
        run(1'b0, 24);
        for (int i = 6; i < NA + ND; i++)
            send_sym(fr[i], -1);
        send_sync();
        chk("align_new_frame", nf_total - nf0, 0);
        chk("align_frame_err", err_total - er0, 0);
        chk("align_dv", dv_l, 0);
        send_frame(12, -1, 0);

        // address symbol 3 = F
        pulse_reset();
        A = 16'h0080;
        run(1'b0, 10);
        send_sync();
        load_frame(0, 4'b0011);
        send_frame(12, -1, 0);
        send_frame(12, -1, 0);
        load_frame(2, 4'b0011);
        send_frame(12, -1, 0);
        send_frame(12, -1, 0);

        // tolerance: 26-tick high accepted, 27-tick high rejected
        load_frame(2, 4'b1111);
        send_frame(12, 8, 26);
        send_frame(12, 8, 27);
        send_frame(12, -1, 0);
        send_frame(12, -1, 0);

        // short frame, then re-confirmation with new data
        load_frame(2, 4'b0110);
        send_frame(11, -1, 0);
        send_frame(12, -1, 0);
        send_frame(12, -1, 0);

        // transmission stops: wait for the hold timer to drop dv
        for (int i = 0; i < HOLD * DIV + 200 && dv_l; i++)
            @(negedge clk);
        chk("hold_dv_fell", dv_l, 0);
        repeat (2) @(negedge clk);
        delta = fall_cyc - nf_cyc;
        $display("hold: dv fell %0d clks after confirmation", delta);
        chk("hold_not_early", delta >= (HOLD - 1) * DIV + 1, 1);
        chk("hold_not_late", delta <= HOLD * DIV, 1);
        chk("hold_D_latched", D_l, 4'b0110);
        chk("hold_dv_m", dv_m, 0);
        chk("hold_D_momentary", D_m, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
